// File: rtl/minn_preamble_inserter.sv
// Minn TX preamble inserter: CP + [A,A,-A,-A] preamble, then payload.
// Define MINN_TX_GAP_EN to append GAP_LEN zero samples after the payload.
module minn_preamble_inserter #(
  parameter int INPUT_WIDTH = 12,
  parameter int NFFT        = 2048,
  parameter int CP_LEN      = 512,
  parameter int PAYLOAD_LEN = 8192,
  parameter int GAP_LEN     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(NFFT/4)-1:0]     cfg_addr,
  input  logic signed [INPUT_WIDTH-1:0] cfg_i,
  input  logic signed [INPUT_WIDTH-1:0] cfg_q,
  input  logic                          frame_req,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [INPUT_WIDTH-1:0] in_ch0_i,
  input  logic signed [INPUT_WIDTH-1:0] in_ch0_q,
  input  logic signed [INPUT_WIDTH-1:0] in_ch1_i,
  input  logic signed [INPUT_WIDTH-1:0] in_ch1_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [INPUT_WIDTH-1:0] out_ch0_i,
  output logic signed [INPUT_WIDTH-1:0] out_ch0_q,
  output logic signed [INPUT_WIDTH-1:0] out_ch1_i,
  output logic signed [INPUT_WIDTH-1:0] out_ch1_q,
  output logic                          frame_start,
  output logic                          frame_done
);
  localparam int W  = INPUT_WIDTH;
  localparam int Q4 = NFFT / 4;
  localparam int AW = $clog2(Q4);
  localparam int M1 = (NFFT > PAYLOAD_LEN) ? NFFT : PAYLOAD_LEN;
  localparam int MX = (M1 > GAP_LEN) ? M1 : GAP_LEN;
  localparam int CW = $clog2(MX + 1);

  typedef logic signed [W-1:0] smp_t;
  localparam smp_t SMIN = {1'b1, {(W-1){1'b0}}};
  localparam smp_t SMAX = {1'b0, {(W-1){1'b1}}};

  if (NFFT % 4 != 0) begin : g_bad_nfft
    $error("NFFT must be divisible by 4");
  end
  if (CP_LEN < 0 || CP_LEN > NFFT) begin : g_bad_cp
    $error("CP_LEN must be within 0..NFFT");
  end
  if (PAYLOAD_LEN < 1) begin : g_bad_pl
    $error("PAYLOAD_LEN must be >= 1");
  end

`ifdef MINN_TX_GAP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CP, S_PRE, S_PAY, S_GAP, S_TAIL
  } st_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CP, S_PRE, S_PAY, S_TAIL
  } st_t;
`endif

  st_t            state;
  logic [CW-1:0]  cnt;
  logic           out_last;
  smp_t           tab_i [Q4];
  smp_t           tab_q [Q4];

  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      tab_i[cfg_addr] <= cfg_i;
      tab_q[cfg_addr] <= cfg_q;
    end
  end

  function automatic smp_t sneg(smp_t x);
    return (x == SMIN) ? SMAX : -x;
  endfunction

  // symbol index of the preamble sample that would load this cycle
  logic [CW-1:0] cur_n;
  logic [CW-1:0] rmod;
  logic [AW-1:0] raddr;
  logic          neg;
  smp_t          pre_i, pre_q;
  smp_t          ld_i0, ld_q0, ld_i1, ld_q1;
  logic          adv;

  always_comb begin
    cur_n = cnt;
    if (state == S_IDLE)
      cur_n = CW'((CP_LEN > 0) ? NFFT - CP_LEN : 0);
    else if (state == S_CP)
      cur_n = CW'(NFFT - CP_LEN) + cnt;
  end

  assign rmod  = cur_n % CW'(Q4);
  assign raddr = rmod[AW-1:0];
  assign neg   = cur_n >= CW'(2 * Q4);
  assign pre_i = neg ? sneg(tab_i[raddr]) : tab_i[raddr];
  assign pre_q = neg ? sneg(tab_q[raddr]) : tab_q[raddr];

  always_comb begin
    ld_i0 = pre_i;
    ld_q0 = pre_q;
    ld_i1 = pre_i;
    ld_q1 = pre_q;
    if (state == S_PAY) begin
      ld_i0 = in_ch0_i;
      ld_q0 = in_ch0_q;
      ld_i1 = in_ch1_i;
      ld_q1 = in_ch1_q;
    end
`ifdef MINN_TX_GAP_EN
    if (state == S_GAP) begin
      ld_i0 = '0;
      ld_q0 = '0;
      ld_i1 = '0;
      ld_q1 = '0;
    end
`endif
  end

  assign adv        = !out_valid || out_ready;
  assign in_ready   = (state == S_PAY) && adv;
  assign frame_done = out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_start <= 1'b0;
      out_ch0_i   <= '0;
      out_ch0_q   <= '0;
      out_ch1_i   <= '0;
      out_ch1_q   <= '0;
    end else begin
      if (adv && (state == S_CP || state == S_PRE
`ifdef MINN_TX_GAP_EN
          || state == S_GAP
`endif
          || (state == S_PAY && in_valid)
          || (state == S_IDLE && frame_req))) begin
        out_ch0_i <= ld_i0;
        out_ch0_q <= ld_q0;
        out_ch1_i <= ld_i1;
        out_ch1_q <= ld_q1;
      end
      case (state)
        S_IDLE: if (frame_req) begin
          busy        <= 1'b1;
          out_valid   <= 1'b1;
          frame_start <= 1'b1;
          if (CP_LEN > 1) begin
            state <= S_CP;
            cnt   <= CW'(1);
          end else if (CP_LEN == 1) begin
            state <= S_PRE;
            cnt   <= '0;
          end else begin
            state <= S_PRE;
            cnt   <= CW'(1);
          end
        end
        S_CP: if (adv) begin
          frame_start <= 1'b0;
          if (cnt == CW'(CP_LEN - 1)) begin
            state <= S_PRE;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        S_PRE: if (adv) begin
          frame_start <= 1'b0;
          if (cnt == CW'(NFFT - 1)) begin
            state <= S_PAY;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        S_PAY: if (adv) begin
          frame_start <= 1'b0;
          out_valid   <= in_valid;
          if (in_valid) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(PAYLOAD_LEN - 1)) begin
              cnt <= '0;
`ifdef MINN_TX_GAP_EN
              if (GAP_LEN > 0) state <= S_GAP;
              else begin
                state    <= S_TAIL;
                out_last <= 1'b1;
              end
`else
              state    <= S_TAIL;
              out_last <= 1'b1;
`endif
            end
          end
        end
`ifdef MINN_TX_GAP_EN
        S_GAP: if (adv) begin
          out_valid <= 1'b1;
          if (cnt == CW'(GAP_LEN - 1)) begin
            state    <= S_TAIL;
            out_last <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
`endif
        S_TAIL: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minn_preamble_inserter.sv
// Bench for minn_preamble_inserter: randomized payload/ready against
// a queue-based frame model built directly from the preamble rules.
module tb_minn_preamble_inserter;
  localparam int W    = 12;
  localparam int NFFT = 16;
  localparam int CP   = 4;
  localparam int PL   = 8;
  localparam int GL   = 3;
`ifdef MINN_TX_GAP_EN
  localparam int GAPN = GL;
`else
  localparam int GAPN = 0;
`endif
  localparam int FLEN = CP + NFFT + PL + GAPN;
  localparam int Q4   = NFFT / 4;

  logic clk, rst, cfg_we, frame_req, busy;
  logic [1:0] cfg_addr;
  logic signed [W-1:0] cfg_i, cfg_q;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q;
  logic signed [W-1:0] out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q;
  logic frame_start, frame_done;

  minn_preamble_inserter #(
    .INPUT_WIDTH(W), .NFFT(NFFT), .CP_LEN(CP),
    .PAYLOAD_LEN(PL), .GAP_LEN(GL)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_i(cfg_i), .cfg_q(cfg_q),
    .frame_req(frame_req), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ch0_i(in_ch0_i), .in_ch0_q(in_ch0_q),
    .in_ch1_i(in_ch1_i), .in_ch1_q(in_ch1_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch0_i(out_ch0_i), .out_ch0_q(out_ch0_q),
    .out_ch1_i(out_ch1_i), .out_ch1_q(out_ch1_q),
    .frame_start(frame_start), .frame_done(frame_done)
  );

  typedef logic [4*W+1:0] rec_t;
  typedef struct packed {
    logic [W-1:0] i0, q0, i1, q1;
  } pay_t;

  rec_t obs[$];
  rec_t exp_q[$];
  pay_t pay_q[$];
  int   tab_i[Q4];
  int   tab_q[Q4];
  int   total = 0, bad = 0;
  int   mode = 0, cyc = 0, pops = 0;
  int   starve_at = -1, starve_left = 0;
  int   done_cnt = 0, d0 = 0;
  int   stall_bad = 0, busy_drop = 0, bubbles = 0, spur = 0;
  bit   in_hs = 0, active = 0, prev_stall = 0;
  logic [4*W:0] held;

  initial clk = 0;
  always #5 clk = ~clk;

  // outputs sampled at negedge, stable until the next active edge
  always @(negedge clk) begin
    in_hs = in_valid && in_ready && !rst;
    if (!rst) begin
      if (out_valid && out_ready) begin
        obs.push_back({out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q,
                       frame_start, frame_done});
        if (frame_done) done_cnt++;
      end
      if (frame_done && !(out_valid && out_ready)) spur++;
      if (prev_stall && {out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q,
                         frame_start} !== held) stall_bad++;
      prev_stall = out_valid && !out_ready;
      held = {out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q, frame_start};
      if (active && !busy) busy_drop++;
      if (active && !out_valid) bubbles++;
    end else prev_stall = 0;
  end

  always @(posedge clk) begin
    pay_t dmy;
    #1;
    if (in_hs && pay_q.size() > 0) begin
      dmy = pay_q.pop_front();
      pops++;
    end
    if (starve_left > 0) starve_left--;
    if (starve_at >= 0 && pops == starve_at) begin
      starve_left = 5;
      starve_at = -1;
    end
    in_valid = (pay_q.size() > 0) && (starve_left == 0);
    if (pay_q.size() > 0)
      {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q} = pay_q[0];
    else
      {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q} = '0;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  end

  function automatic int nsat(int x);
    int v = -x;
    if (v > (1 << (W - 1)) - 1) v = (1 << (W - 1)) - 1;
    return v;
  endfunction

  task automatic wr_tab(input int a, input int vi, input int vq);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = 2'(a); cfg_i = W'(vi); cfg_q = W'(vq);
    @(posedge clk); #1;
    cfg_we = 0;
    tab_i[a] = vi;
    tab_q[a] = vq;
  endtask

  task automatic prep(input bit fixed);
    pay_t p;
    pay_t pl[$];
    rec_t t;
    int n, vi, vq;
    pay_q.delete(); exp_q.delete(); obs.delete();
    pops = 0; stall_bad = 0; busy_drop = 0; bubbles = 0; spur = 0;
    d0 = done_cnt;
    for (int k = 0; k < PL; k++) begin
      p.i0 = fixed ? W'(100 + k) : W'($urandom);
      p.q0 = W'($urandom);
      p.i1 = W'($urandom);
      p.q1 = W'($urandom);
      pl.push_back(p);
    end
    for (int k = 0; k < CP + NFFT; k++) begin
      n  = (k < CP) ? NFFT - CP + k : k - CP;
      vi = tab_i[n % Q4];
      vq = tab_q[n % Q4];
      if (n / Q4 >= 2) begin
        vi = nsat(vi);
        vq = nsat(vq);
      end
      exp_q.push_back({W'(vi), W'(vq), W'(vi), W'(vq), k == 0, 1'b0});
    end
    foreach (pl[k]) exp_q.push_back({pl[k], 2'b00});
    for (int k = 0; k < GAPN; k++) exp_q.push_back('0);
    t = exp_q[FLEN-1];
    t[0] = 1'b1;
    exp_q[FLEN-1] = t;
    foreach (pl[k]) pay_q.push_back(pl[k]);
  endtask

  task automatic kick();
    @(posedge clk); #1 frame_req = 1;
    @(posedge clk); #1 frame_req = 0;
    active = 1;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (done_cnt > d0) break;
    end
    active = 0;
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_timeout got=no frame_done want=frame_done", tag);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, busy, in_ready, frame_start, frame_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000",
               {out_valid, busy, in_ready, frame_start, frame_done});
    end
    total++;
    if ({out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0",
               {out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q});
    end
  endtask

  task automatic test_basic();
    mode = 0;
    for (int r = 0; r < Q4; r++) wr_tab(r, r + 1, 0);
    prep(1);
    kick();
    wait_done("basic");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL basic_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL basic_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
    total++;
    if (bubbles !== 0 || spur !== 0) begin
      bad++;
      $display("FAIL basic_flow got=%0d/%0d want=0/0", bubbles, spur);
    end
  endtask

  task automatic test_backpressure();
    mode = 1;
    prep(0);
    kick();
    wait_done("bp");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL bp_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL bp_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
    total++;
    if (stall_bad !== 0 || busy_drop !== 0) begin
      bad++;
      $display("FAIL bp_hold got=%0d/%0d want=0/0", stall_bad, busy_drop);
    end
  endtask

  task automatic test_saturation();
    mode = 2;
    wr_tab(0, -2048, -2048);
    for (int r = 1; r < Q4; r++)
      wr_tab(r, int'($urandom_range(0, 4000)) - 2000,
             int'($urandom_range(0, 4000)) - 2000);
    prep(0);
    kick();
    wait_done("sat");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL sat_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL sat_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
    if (obs.size() > CP + 8) begin
      total++;
      if (obs[CP][4*W+1 -: 2*W] !== {12'h800, 12'h800}) begin
        bad++;
        $display("FAIL sat_pos got=%h want=800800", obs[CP][4*W+1 -: 2*W]);
      end
      total++;
      if (obs[CP+8][4*W+1 -: 2*W] !== {12'h7ff, 12'h7ff}) begin
        bad++;
        $display("FAIL sat_neg got=%h want=7ff7ff", obs[CP+8][4*W+1 -: 2*W]);
      end
    end
    total++;
    if (stall_bad !== 0) begin
      bad++;
      $display("FAIL sat_hold got=%0d want=0", stall_bad);
    end
  endtask

  task automatic test_starvation();
    mode = 0;
    prep(0);
    starve_at = 3;
    kick();
    wait_done("starve");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL starve_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL starve_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
    total++;
    if (bubbles == 0) begin
      bad++;
      $display("FAIL starve_bubble got=%0d want=>0", bubbles);
    end
    total++;
    if (busy_drop !== 0) begin
      bad++;
      $display("FAIL starve_busy got=%0d want=0", busy_drop);
    end
  endtask

  task automatic test_busy_gating();
    mode = 0;
    prep(0);
    kick();
    for (int c = 0; c < 200 && obs.size() < CP + 3; c++) @(posedge clk);
    #1;
    frame_req = 1; cfg_we = 1; cfg_addr = 2'd1; cfg_i = 12'sd777;
    cfg_q = -12'sd777;
    repeat (3) @(posedge clk);
    #1 frame_req = 0; cfg_we = 0;
    wait_done("gate1");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL gate1_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL gate1_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL gate_restart got=%b want=00", {busy, out_valid});
    end
    prep(0);
    kick();
    wait_done("gate2");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL gate2_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL gate2_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 0;
    prep(0);
    kick();
    for (int c = 0; c < 200 && obs.size() < CP + 10; c++) @(posedge clk);
    #1;
    rst = 1;
    active = 0;
    @(posedge clk); #1;
    rst = 0;
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_ctl got=%b want=00", {out_valid, busy});
    end
    repeat (2) @(posedge clk);
    prep(0);
    kick();
    wait_done("rstmid");
    total++;
    if (obs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL rstmid_len got=%0d want=%0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      total++;
      if (obs[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL rstmid_s%0d got=%h want=%h", k, obs[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    rst = 1; cfg_we = 0; cfg_addr = 0; cfg_i = 0; cfg_q = 0;
    frame_req = 0; in_valid = 0; out_ready = 1;
    {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q} = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_starvation();
    test_busy_gating();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/minn_preamble_inserter.md
Name: minn_preamble_inserter

Overview:
Transmit-side counterpart of the Minn receive detector. On request, emits one Minn preamble symbol with cyclic prefix, then passes a fixed-length payload from an upstream source. The preamble is a quarter sequence A repeated as [A, A, -A, -A] over NFFT samples. The same preamble goes to both antenna channels; the payload is passed through per channel. It sits between the payload modulator/IFFT and the DAC interface, and drives a frame_start marker aligned with the first emitted sample.

Parameters:
INPUT_WIDTH, 12, signed sample width per I/Q component
NFFT, 2048, preamble symbol length; must be divisible by 4 (elaboration $error otherwise)
CP_LEN, 512, cyclic prefix length; must satisfy 0 <= CP_LEN <= NFFT (elaboration $error otherwise)
PAYLOAD_LEN, 8192, payload samples per frame; must be >= 1
GAP_LEN, 64, zero samples appended after the payload (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  quarter-table write strobe
cfg_addr  in  clog2(NFFT/4)  quarter-table index
cfg_i  in  INPUT_WIDTH  quarter-table I value (signed)
cfg_q  in  INPUT_WIDTH  quarter-table Q value (signed)
frame_req  in  1  start-frame pulse
busy  out  1  high from request acceptance until the frame ends
in_valid  in  1  payload sample valid
in_ready  out  1  payload sample accepted when in_valid && in_ready
in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q  in  INPUT_WIDTH each  payload samples (signed)
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q  out  INPUT_WIDTH each  output samples (signed)
frame_start  out  1  high with the first CP sample of each frame (first preamble sample if CP_LEN=0)
frame_done  out  1  one-cycle pulse when the last sample of the frame is accepted downstream

Behaviour:
- Reset:
  - All outputs are 0: out_valid, busy, in_ready, frame_start, frame_done and the data outputs.
  - State returns to IDLE and counters clear.
  - Quarter-table contents are NOT cleared.
- Quarter table:
  - NFFT/4 entries, written synchronously when cfg_we && !busy.
  - Writes while busy are ignored.
  - Read is combinational from the register array.
- Output register:
  - Single stage. A new sample loads when (!out_valid || out_ready).
  - Data and frame_start are held stable while out_valid && !out_ready.
- States:
  - IDLE -> CP on frame_req, loading the first sample. Latency: out_valid rises the cycle after frame_req. If CP_LEN=0, IDLE goes directly to PRE. frame_req while busy is ignored.
  - CP: emits symbol index n = NFFT-CP_LEN+k for k = 0..CP_LEN-1, then goes to PRE.
  - PRE: emits n = 0..NFFT-1, then goes to PAYLOAD.
  - PAYLOAD:
    - in_ready = (!out_valid || out_ready).
    - Each handshake loads the payload sample into the output register.
    - While in_valid is low, out_valid drops after the current sample drains (bubbles are allowed).
    - After PAYLOAD_LEN samples: goes to GAP (feature on) or IDLE.
  - in_ready is 0 in every state other than PAYLOAD.
- Preamble sample n:
  - q = n / (NFFT/4), r = n mod (NFFT/4); value = table[r], negated when q >= 2.
  - Both channels carry the same value.
- Negation saturates: -(-2^(W-1)) yields 2^(W-1)-1. Components are negated independently.
- frame_start is high only on the first sample of the frame and follows the held-data rule.
- frame_done:
  - Pulses on the cycle the final sample (last payload, or last gap sample) handshakes.
  - busy falls the same cycle.
  - frame_req is accepted on the next cycle at the earliest.
- Reset mid-frame: aborts immediately, drops out_valid and returns to IDLE. No partial-frame completion.

Optional Feature:
MINN_TX_GAP_EN:
- Defined: after PAYLOAD, a GAP state emits GAP_LEN zero-valued samples (out_valid=1, both channels 0) under the same handshake; frame_done fires on the last gap sample. GAP_LEN=0 skips GAP.
- Undefined: no GAP state exists, GAP_LEN is unused, and frame_done fires on the last payload sample.

Test Plan:
1. Basic frame: NFFT=16, CP_LEN=4, PAYLOAD_LEN=8. Table I={1,2,3,4}, Q=0. out_ready=1, payload I=100..107. Required:
   - ch0_i sequence: -1,-2,-3,-4, 1,2,3,4,1,2,3,4,-1,-2,-3,-4,-1,-2,-3,-4, then 100..107.
   - frame_start on sample 0 only.
   - frame_done on sample 27.
2. Backpressure: same config, out_ready toggling 1,0,0,1... -> identical sequence; data and frame_start held stable during stalls; no sample dropped or duplicated.
3. Saturation: table[0]=(-2048,-2048) with W=12 -> negated quarters emit (2047,2047); non-negated quarters emit (-2048,-2048).
4. Payload starvation: in_valid low for 5 cycles mid-payload -> out_valid low in the gap; 8 payload samples still delivered in order; busy stays high.
5. Busy gating: frame_req and cfg_we asserted during PRE -> no restart; table unchanged in the next frame.
6. Reset mid-PRE at sample 10 -> the cycle after reset, out_valid=0 and busy=0. A new frame_req produces a full, correct frame. With MINN_TX_GAP_EN and GAP_LEN=3, three zero samples follow the payload and frame_done fires on sample 30.
